if_fetch_unit: RTL
==================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch initiator for the synchronous instruction memory. Generates the
//  word address each cycle and consumes the 1-cycle registered read data. Tracks the PC
//  of the in-flight read, absorbs decode stalls with a 1-entry hold buffer, and squashes
//  on branch/jump redirect. Delivers {pc, instr, valid} to the decode stage.
// PARAMETERS
//  RESET_PC  32'h0000_0000  first fetch address after reset
//  NOP_INSTR 32'h0000_0013  value driven on instr_out when instr_valid=0 (addi x0,x0,0)
// PORTS
//  clk            in   1   single clock, all state updates on posedge
//  rst            in   1   synchronous reset, active-high
//  imem_addr      out  32  byte address to imem; imem indexes addr[31:2]
//  imem_rdata     in   32  imem registered data; word for addr presented previous cycle
//  stall          in   1   decode not accepting; transfer only when instr_valid && !stall
//  redirect_valid in   1   taken branch/jump this cycle; overrides stall
//  redirect_pc    in   32  redirect target; bits[1:0] ignored (forced 2'b00)
//  instr_out      out  32  instruction to decode
//  pc_out         out  32  PC of instr_out
//  instr_valid    out  1   instr_out/pc_out meaningful
// BEHAVIOUR
//  State: issue_pc (next addr to read), infl_pc/infl_v (read returning now),
//         hold_q/hold_pc/hold_v (instr captured during stall).
//  Reset (rst=1 at edge): issue_pc<=RESET_PC, infl_v<=0, hold_v<=0. While rst high and
//   first cycle after: instr_valid=0, instr_out=NOP_INSTR, pc_out=0. imem_addr=issue_pc.
//  Latency: address issued cycle t -> instr_valid with that word at cycle t+1.
//  imem_addr comb: redirect_valid ? {redirect_pc[31:2],2'b00} : issue_pc.
//  Output select: hold_v ? (hold_q,hold_pc) : (imem_rdata,infl_pc); valid = (hold_v|infl_v)
//   & !redirect_valid. When valid=0, instr_out=NOP_INSTR.
//  Normal (no stall, no redirect): issue_pc<=issue_pc+4; infl_pc<=issue_pc; infl_v<=1;
//   hold_v<=0. Steady state: one instr per cycle, consecutive PCs +4.
//  Stall, first cycle (stall=1, hold_v=0, infl_v=1): hold_q<=imem_rdata, hold_pc<=infl_pc,
//   hold_v<=1; issue_pc, infl_pc frozen. imem_addr stays issue_pc, so imem_rdata
//   now carries word at infl_pc... no: carries word at issue_pc (=infl_pc+4) next cycle.
//  Stall continuing: all state frozen; outputs stable from hold buffer.
//  Stall release (stall=0, hold_v=1): hold instr transfers; hold_v<=0; infl_pc<=issue_pc,
//   infl_v<=1, issue_pc<=issue_pc+4. Next cycle delivers word at old issue_pc. No bubble,
//   no duplicate, no skipped PC.
//  Redirect (any stall value): instr_valid=0 this cycle (squash); hold_v<=0;
//   infl_pc<=target, infl_v<=1; issue_pc<=target+4. Target instr valid next cycle
//   (exactly 1 bubble). Redirect during stall discards the held instr.
//  Redirect while rst=1: rst wins. Back-to-back redirects: last one wins each cycle.
//  Wrap-around: issue_pc+4 wraps modulo 2^32, no flag.
// STRUCTURE
//  Shared package (rv32i_pkg): XLEN=32, RESET_PC default, NOP_INSTR encoding, INSTR_BYTES=4.
//  One sub-module: if_hold_buf (1-entry capture/hold of {pc,instr} with load/clear/valid).
//  Top: PC register + next-PC mux + in-flight tracker + output mux.
// TESTING
//  T1 reset: rst 3 cycles, release -> imem_addr=0x0, valid=0 one cycle, then pc_out=0x0
//   instr=mem[0], pc_out 0x4,0x8,0xC on successive cycles.
//  T2 stall: stall=1 at pc_out=0x8 for 4 cycles -> instr/pc held at 0x8 all cycles;
//   release -> 0x8 transfers, next cycle pc_out=0xC with mem[3]; no gaps or repeats.
//  T3 redirect: redirect_valid=1, redirect_pc=0x100 while pc_out=0x10 -> valid=0 that cycle,
//   imem_addr=0x100; next cycle pc_out=0x100, then 0x104.
//  T4 redirect during stall: stall=1 holding 0x20, redirect 0x40 -> held instr dropped,
//   next cycle pc_out=0x40 valid (stall low) or held at 0x40 (stall high).
//  T5 misaligned/wrap: redirect_pc=0x203 -> fetch 0x200; redirect 0xFFFF_FFFC -> next pc 0x0.
//  T6 reset mid-stall: rst=1 with hold_v=1 -> valid=0, NOP out; restart at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared RV32I fetch constants, types and small PC helpers.
// Imported by the fetch unit, its hold buffer and its interface.
package if_fetch_unit_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t RESET_PC_DEF  = 32'h0000_0000;
  localparam word_t NOP_INSTR_DEF = 32'h0000_0013;

  // Decoded per-cycle state update selected by the fetch unit.
  typedef enum logic [2:0] {
    UpdReset,
    UpdRedirect,
    UpdCapture,
    UpdFreeze,
    UpdAdvance
  } upd_e;

  function automatic word_t align_word(input word_t addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

  // Wraps modulo 2^XLEN.
  function automatic word_t next_pc(input word_t pc);
    return pc + word_t'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus: imem request/response, decode handshake and redirect.
// The master modport is the fetch unit's view.
interface if_fetch_unit_if;
  import if_fetch_unit_pkg::*;

  word_t imem_addr;
  word_t imem_rdata;
  logic  stall;
  logic  redirect_valid;
  word_t redirect_pc;
  word_t instr_out;
  word_t pc_out;
  logic  instr_valid;

  modport master (
    output imem_addr,
    output instr_out,
    output pc_out,
    output instr_valid,
    input  imem_rdata,
    input  stall,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  imem_addr,
    input  instr_out,
    input  pc_out,
    input  instr_valid,
    output imem_rdata,
    output stall,
    output redirect_valid,
    output redirect_pc
  );

endinterface

// File: rtl/if_fetch_unit_hold_buf.sv
// One-entry {pc, instr} capture buffer used to absorb decode stalls.
// Reset and clear take priority over load.
module if_hold_buf
  import if_fetch_unit_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  clear,
  input  word_t cap_pc,
  input  word_t cap_instr,
  output word_t pc,
  output word_t instr,
  output logic  valid
);

  word_t pc_q, pc_d;
  word_t instr_q, instr_d;
  logic  valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      pc_d    = cap_pc;
      instr_d = cap_instr;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc    = pc_q;
  assign instr = instr_q;
  assign valid = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch initiator: PC register, next-PC mux, in-flight read tracker
// and decode output mux in front of a 1-cycle registered instruction memory.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter word_t RESET_PC  = RESET_PC_DEF,
  parameter word_t NOP_INSTR = NOP_INSTR_DEF
) (
  input logic            clk,
  input logic            rst,
  if_fetch_unit_if.master bus
);

  word_t issue_pc_q, issue_pc_d;
  word_t infl_pc_q, infl_pc_d;
  logic  infl_v_q, infl_v_d;

  word_t hold_pc, hold_instr;
  logic  hold_v, hold_load, hold_clear;

  upd_e  upd;
  logic  redirect;
  word_t target;
  logic  valid;

  // Reset overrides a coincident redirect.
  assign redirect = bus.redirect_valid & ~rst;
  assign target   = align_word(bus.redirect_pc);

  always_comb begin
    upd = UpdAdvance;
    if (rst) begin
      upd = UpdReset;
    end else if (redirect) begin
      upd = UpdRedirect;
    end else if (bus.stall) begin
      upd = (!hold_v && infl_v_q) ? UpdCapture : UpdFreeze;
    end
  end

  always_comb begin
    issue_pc_d = issue_pc_q;
    infl_pc_d  = infl_pc_q;
    infl_v_d   = infl_v_q;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    unique case (upd)
      UpdReset: begin
        issue_pc_d = RESET_PC;
        infl_pc_d  = '0;
        infl_v_d   = 1'b0;
      end
      UpdRedirect: begin
        issue_pc_d = next_pc(target);
        infl_pc_d  = target;
        infl_v_d   = 1'b1;
        hold_clear = 1'b1;
      end
      // imem_addr stays at issue_pc, so the read for issue_pc is simply re-done
      // until the stall releases.
      UpdCapture: begin
        hold_load = 1'b1;
      end
      UpdFreeze: begin
      end
      UpdAdvance: begin
        issue_pc_d = next_pc(issue_pc_q);
        infl_pc_d  = issue_pc_q;
        infl_v_d   = 1'b1;
        hold_clear = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_pc_q <= RESET_PC;
      infl_pc_q  <= '0;
      infl_v_q   <= 1'b0;
    end else begin
      issue_pc_q <= issue_pc_d;
      infl_pc_q  <= infl_pc_d;
      infl_v_q   <= infl_v_d;
    end
  end

  if_hold_buf u_hold_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (hold_load),
    .clear     (hold_clear),
    .cap_pc    (infl_pc_q),
    .cap_instr (bus.imem_rdata),
    .pc        (hold_pc),
    .instr     (hold_instr),
    .valid     (hold_v)
  );

  assign valid = (hold_v | infl_v_q) & ~bus.redirect_valid & ~rst;

  always_comb begin
    bus.imem_addr   = redirect ? target : issue_pc_q;
    bus.instr_valid = valid;
    bus.instr_out   = NOP_INSTR;
    bus.pc_out      = '0;
    if (valid) begin
      bus.instr_out = hold_v ? hold_instr : bus.imem_rdata;
      bus.pc_out    = hold_v ? hold_pc : infl_pc_q;
    end
  end

endmodule
